// File: rtl/demux1_4_buf.sv
// Buffered 1:4 demux: one producer word per cycle steered by sel into one of
// four single-entry lane buffers, each drained by its own ack.

module demux1_4_buf_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // A load wins over an ack so a full lane can be refilled in the cycle it drains.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (ack_i && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
endmodule

module demux1_4_buf #(
  parameter int WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [WIDTH-1:0]          in_i,
  input  logic [1:0]                sel_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic [3:0][WIDTH-1:0]     out_data_o,
  output logic [3:0]                out_valid_o,
  input  logic [3:0]                out_ack_i,
  output logic [7:0]                accept_count_o
);
  localparam int NUM_LANES = 4;

  logic                 accept;
  logic [NUM_LANES-1:0] load;
  logic [7:0]           cnt_q, cnt_d;

  // Readiness looks only at the addressed lane; other full lanes never stall.
  assign in_ready_o = ~reset_i & (~out_valid_o[sel_i] | out_ack_i[sel_i]);
  // Gating by in_valid keeps an undriven sel out of the lane state.
  assign accept     = in_valid_i & in_ready_o;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign load[i] = accept & (sel_i == 2'(i));
    demux1_4_buf_lane #(.WIDTH(WIDTH)) u_lane (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .load_i  (load[i]),
      .data_i  (in_i),
      .ack_i   (out_ack_i[i]),
      .data_o  (out_data_o[i]),
      .valid_o (out_valid_o[i])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign accept_count_o = cnt_q;
endmodule

// File: doc/demux1_4_buf.md
# demux1_4_buf

Buffered 1-to-4 demultiplexer: the write-side counterpart of the 4:1 read-select mux in the CPU datapath. It accepts one WIDTH-bit word per cycle from a single producer, steers it by a 2-bit select into one of four single-entry lane buffers, and holds it until that lane's consumer acknowledges. A valid/ready handshake provides back-pressure per lane, and a saturating counter tracks accepted words for debug.

## Interface

Parameters:

- WIDTH, 8, data word width.

Ports:

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  data word from the producer.
- sel  input  2  destination lane index, 0..3.
- in_valid  input  1  producer offers in/sel this cycle.
- in_ready  output  1  block can accept the offer this cycle (combinational).
- out_data  output  4 x WIDTH  lane buffers; out_data[i] is lane i.
- out_valid  output  4  lane i holds an unconsumed word.
- out_ack  input  4  consumer of lane i takes the word this cycle.
- accept_count  output  8  saturating count of accepted words.

## Operation

- Accept event: in_valid & in_ready at a rising edge with reset low.
- in_ready = ~reset & (~out_valid[sel] | out_ack[sel]).
  - A full lane can accept in the same cycle its consumer acks it (pass-through refill).
  - in_ready depends only on the addressed lane. Other lanes being full never stalls.
- Per-lane update at each edge, priority highest first:
  1. reset: out_data[i]=0, out_valid[i]=0.
  2. Accept with sel==i: out_data[i]<=in, out_valid[i]<=1. This applies even if out_ack[i] is high; the new word replaces the acked one.
  3. out_ack[i] & out_valid[i]: out_valid[i]<=0. out_data[i] keeps its last value.
  4. Otherwise: hold.
- out_ack[i] on an empty lane is ignored and has no side effects.
- in and sel are don't-care when in_valid is low. The X on sel must not propagate into state.
- accept_count:
  - Reset to 0.
  - +1 per accept event.
  - Saturates at 255 and never wraps.
- No internal FSM beyond the per-lane full/empty bit. Each lane is an independent 2-state machine:
  - EMPTY to FULL on accept.
  - FULL to EMPTY on ack without accept.
  - FULL to FULL on accept (with or without ack).

## Timing

- Reset values: out_data all 0, out_valid 4'b0000, accept_count 0, in_ready 0 while reset is high.
- First cycle after reset deasserts: in_ready=1 for any sel.
- Latency:
  - Accept at edge N: out_data/out_valid visible after edge N, and accept_count increments at edge N.
  - Ack at edge N: out_valid clears after edge N.
- Throughput:
  - One word per cycle across lanes.
  - One word per cycle into a single lane if its consumer acks every cycle.
- Reset mid-operation: all buffered words are discarded at the reset edge with no ack required. Pending acks in that cycle are ignored.
- in_ready has a combinational path from sel, out_ack and reset. It has no path from in.

## Test plan

- Basic route: after reset, drive in=8'hA5, sel=2, in_valid for 1 cycle. Required next cycle: out_valid=4'b0100, out_data[2]=8'hA5, accept_count=1, other lanes 0.
- Back-pressure and refill:
  - With lane 2 full, offer in=8'h3C, sel=2, out_ack=0. Required: in_ready=0, lane 2 unchanged.
  - Then raise out_ack[2] in the same cycle as the offer. Required: accept; out_data[2]=8'h3C, out_valid[2] stays 1, count=2.
- Lane sweep: offer 8'h10..8'h13 to sel 0..3 on consecutive cycles with no acks, then assert out_ack=4'hF for one cycle.
  - Required after the sweep: all lanes valid, out_data[i]=8'h10+i, count=4, in_ready=1 throughout.
  - Required after the ack: out_valid=0, data retained.
- Spurious ack: assert out_ack=4'hF with all lanes empty. Required: no state change, count unchanged.
- Saturation: perform 260 accepts with continuous acks. Required: accept_count=255 and held there.
- Reset mid-stream: fill lanes 0 and 3, assert reset for 1 cycle with in_valid=1 and out_ack=4'b1000.
  - Required: in_ready=0 during reset.
  - Required after the reset edge: all outputs 0 and no accept counted.
